// File: rtl/entropy_conditioner_pkg.sv
// Shared constants for the entropy conditioner: default sizes and von Neumann pair states.
// Imported by entropy_conditioner and vn_debias.
package entropy_conditioner_pkg;

    localparam int DEFAULT_WORD_W     = 32;
    localparam int DEFAULT_RCT_CUTOFF = 32;

    localparam logic [0:0] PAIR_FIRST  = 1'b0;
    localparam logic [0:0] PAIR_SECOND = 1'b1;

    // Width needed to count 0..word_w bits held in the packing register.
    function automatic int fill_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/entropy_conditioner_vn_debias.sv
// vn_debias: von Neumann pairing FSM. Unequal pairs emit the first sample, equal pairs are
// discarded; clear returns the pair state to FIRST and suppresses any emission that cycle.
module vn_debias
    import entropy_conditioner_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw_bit,
    input  logic raw_valid,
    input  logic clear,
    output logic emit_bit,
    output logic bit_valid
);

    logic [0:0] state_q, state_d;
    logic       first_q, first_d;

    // (1,0) emits 1 and (0,1) emits 0, so the emitted bit is always the stored first sample.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        bit_valid = 1'b0;
        emit_bit  = first_q;
        if (clear) begin
            state_d = PAIR_FIRST;
        end else if (raw_valid) begin
            if (state_q == PAIR_FIRST) begin
                first_d = raw_bit;
                state_d = PAIR_SECOND;
            end else begin
                state_d   = PAIR_FIRST;
                bit_valid = (first_q != raw_bit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAIR_FIRST;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/entropy_conditioner.sv
// entropy_conditioner: debiases raw ring-oscillator samples, packs them MSB-first into words
// and offers them on a valid/ready port. Define ENTROPY_HEALTH_EN to add the repetition-count test.
module entropy_conditioner
    import entropy_conditioner_pkg::*;
#(
    parameter  int WORD_W     = DEFAULT_WORD_W,
    parameter  int RCT_CUTOFF = DEFAULT_RCT_CUTOFF,
    localparam int FILL_W     = fill_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              raw_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FILL_W-1:0] fill_level,
    output logic              health_fail,
    input  logic              health_clr
);

    logic accept, trip, fail_now;
    logic emit_bit, bit_valid;

    assign accept = raw_valid & en & ~fail_now;

    vn_debias u_debias (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_bit   (raw_bit),
        .raw_valid (accept),
        .clear     (~en | trip),
        .emit_bit  (emit_bit),
        .bit_valid (bit_valid)
    );

`ifdef ENTROPY_HEALTH_EN
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

    logic [RCT_W-1:0] rct_q, rct_d, rct_next;
    logic             prev_q, prev_d;
    logic             health_q, health_d;

    // A clear on the same edge as a would-be trip wins, so no trip is raised at all.
    always_comb begin
        rct_next = (rct_q != '0 && raw_bit == prev_q) ? rct_q + 1'b1 : RCT_W'(1);
        trip     = accept & ~health_clr & (rct_next == RCT_W'(RCT_CUTOFF));
        rct_d    = rct_q;
        prev_d   = prev_q;
        health_d = health_q;
        if (accept) begin
            rct_d  = rct_next;
            prev_d = raw_bit;
        end
        if (health_clr) begin
            rct_d    = '0;
            health_d = 1'b0;
        end else if (trip) begin
            health_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rct_q    <= '0;
            prev_q   <= 1'b0;
            health_q <= 1'b0;
        end else begin
            rct_q    <= rct_d;
            prev_q   <= prev_d;
            health_q <= health_d;
        end
    end

    assign fail_now    = health_q;
    assign health_fail = health_q;
`else
    logic unused_health;
    assign unused_health = health_clr ^ (RCT_CUTOFF > 1);
    assign trip          = 1'b0;
    assign fail_now      = 1'b0;
    assign health_fail   = 1'b0;
`endif

    logic [WORD_W-1:0] shreg_q, shreg_d, data_q, data_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              valid_q, valid_d;
    logic              full, transfer;

    assign full     = (fill_q == FILL_W'(WORD_W));
    assign transfer = full & (~valid_q | out_ready);

    // A bit arriving on a transfer edge starts the next word; while full with the slot busy it is dropped.
    always_comb begin
        shreg_d = shreg_q;
        fill_d  = fill_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (trip) begin
            shreg_d = '0;
            fill_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q & out_ready) valid_d = 1'b0;
            if (transfer) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                fill_d  = '0;
            end
            if (bit_valid & (transfer | ~full)) begin
                shreg_d = {shreg_q[WORD_W-2:0], emit_bit};
                fill_d  = transfer ? FILL_W'(1) : fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign fill_level = fill_q;

endmodule

// File: tb/tb_entropy_conditioner.sv
// Self-checking bench for entropy_conditioner against a queue-based reference model.
// Health-test scenarios follow ENTROPY_HEALTH_EN when it is defined for the build.
module tb_entropy_conditioner;

    localparam int W   = 32;
    localparam int RCT = 32;
    localparam int FW  = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          raw_bit = 1'b0;
    logic          raw_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          health_clr = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [FW-1:0] fill_level;
    logic          health_fail;

    int total = 0;
    int bad = 0;

    // Reference model: pending debiased bits, one output slot, health state.
    int           mFirst;
    bit           mBits[$];
    bit           mSlotValid;
    logic [W-1:0] mSlotWord;
    bit           mFail;
    int           mRct;
    bit           mPrev;

    entropy_conditioner #(.WORD_W(W), .RCT_CUTOFF(RCT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .health_fail (health_fail),
        .health_clr  (health_clr)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mFirst     = -1;
        mBits.delete();
        mSlotValid = 0;
        mSlotWord  = '0;
        mFail      = 0;
        mRct       = 0;
        mPrev      = 0;
    endfunction

    function automatic logic [W-1:0] packBits();
        logic [W-1:0] w = '0;
        foreach (mBits[i]) w = {w[W-2:0], mBits[i]};
        return w;
    endfunction

    // One clock edge of the specified behaviour, given the inputs present before the edge.
    function automatic void modelStep(bit v, bit b, bit rdy, bit e, bit clr);
        int  emit = -1;
        bit  trip = 0;
        bit  acc  = v && e && !mFail;
        if (!e) mFirst = -1;
        else if (acc) begin
`ifdef ENTROPY_HEALTH_EN
            mRct  = (mRct > 0 && b == mPrev) ? mRct + 1 : 1;
            mPrev = b;
            trip  = (mRct == RCT) && !clr;
`endif
            if (mFirst < 0) mFirst = b;
            else begin
                if (mFirst != int'(b)) emit = mFirst;
                mFirst = -1;
            end
        end
`ifdef ENTROPY_HEALTH_EN
        if (clr) begin
            mFail = 0;
            mRct  = 0;
        end
`endif
        if (trip) begin
            mFail = 1;
            mBits.delete();
            mSlotValid = 0;
            mFirst = -1;
            return;
        end
        if (mBits.size() == W && (!mSlotValid || rdy)) begin
            mSlotWord  = packBits();
            mSlotValid = 1;
            mBits.delete();
            if (emit >= 0) mBits.push_back(emit[0]);
        end else begin
            if (mSlotValid && rdy) mSlotValid = 0;
            if (emit >= 0 && mBits.size() < W) mBits.push_back(emit[0]);
        end
    endfunction

    task automatic cycle(input bit v, input bit b, input bit rdy, input bit e, input bit clr);
        raw_valid  = v;
        raw_bit    = b;
        out_ready  = rdy;
        en         = e;
        health_clr = clr;
        @(posedge clk);
        modelStep(v, b, rdy, e, clr);
        #1;
        raw_valid  = 1'b0;
        health_clr = 1'b0;
    endtask

    task automatic feedPair(input bit f, input bit s, input bit rdy);
        cycle(1'b1, f, rdy, 1'b1, 1'b0);
        if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, rdy, 1'b1, 1'b0);
        cycle(1'b1, s, rdy, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        #1;
        rst_n = 1'b0;
        raw_valid = 1'($urandom);
        raw_bit = 1'($urandom);
        out_ready = 1'($urandom);
        en = 1'b1;
        repeat (3) @(posedge clk);
        modelReset();
        #2;
        raw_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        modelReset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
        total++;
        if (fill_level !== '0) begin bad++; $display("[TB] FAIL reset_fill got=%0d want=0", fill_level); end
        total++;
        if (health_fail !== 1'b0) begin bad++; $display("[TB] FAIL reset_health got=%b want=0", health_fail); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_packing();
        for (int i = 0; i < W; i++) begin
            if (i % 2 == 0) feedPair(1'b1, 1'b0, 1'b1);
            else feedPair(1'b0, 1'b1, 1'b1);
        end
        total++;
        if (fill_level !== FW'(W) || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pack_full fill=%0d valid=%b want fill=%0d valid=0", fill_level, out_valid, W);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hAAAAAAAA || fill_level !== '0) begin
            bad++;
            $display("[TB] FAIL pack_word valid=%b data=%h fill=%0d want valid=1 data=aaaaaaaa fill=0",
                     out_valid, out_data, fill_level);
        end
        total++;
        if (out_data !== mSlotWord) begin bad++; $display("[TB] FAIL pack_model got=%h want=%h", out_data, mSlotWord); end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pack_consume got=%b want=0", out_valid); end
    endtask

    task automatic test_bias();
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) feedPair(1'b0, 1'b0, 1'b1);
            else feedPair(1'b1, 1'b1, 1'b1);
            total++;
            if (fill_level !== '0 || out_valid !== 1'b0 || health_fail !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bias_pair%0d fill=%0d valid=%b health=%b want all 0",
                         i, fill_level, out_valid, health_fail);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] word1;
        for (int i = 0; i < 74; i++) begin
            if ($urandom_range(0, 1) == 1) feedPair(1'b1, 1'b0, 1'b0);
            else feedPair(1'b0, 1'b1, 1'b0);
        end
        word1 = mSlotWord;
        total++;
        if (out_valid !== 1'b1 || out_data !== word1 || fill_level !== FW'(W)) begin
            bad++;
            $display("[TB] FAIL bp_hold valid=%b data=%h fill=%0d want valid=1 data=%h fill=%0d",
                     out_valid, out_data, fill_level, word1, W);
        end
        total++;
        if (mBits.size() != W) begin bad++; $display("[TB] FAIL bp_model_fill got=%0d want=%0d", mBits.size(), W); end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== mSlotWord || fill_level !== '0) begin
            bad++;
            $display("[TB] FAIL bp_word2 valid=%b data=%h fill=%0d want valid=1 data=%h fill=0",
                     out_valid, out_data, fill_level, mSlotWord);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_health();
        for (int i = 0; i < 5; i++) feedPair(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < RCT; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            total++;
            if (health_fail !== mFail || fill_level !== FW'(mBits.size())) begin
                bad++;
                $display("[TB] FAIL health_run%0d health=%b fill=%0d want health=%b fill=%0d",
                         i, health_fail, fill_level, mFail, mBits.size());
            end
        end
`ifdef ENTROPY_HEALTH_EN
        total++;
        if (health_fail !== 1'b1 || fill_level !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL health_trip health=%b fill=%0d valid=%b want 1/0/0", health_fail, fill_level, out_valid);
        end
        for (int i = 0; i < 8; i++) feedPair(1'b1, 1'b0, 1'b1);
        total++;
        if (fill_level !== '0 || health_fail !== 1'b1) begin
            bad++;
            $display("[TB] FAIL health_ignore fill=%0d health=%b want fill=0 health=1", fill_level, health_fail);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if (health_fail !== 1'b0) begin bad++; $display("[TB] FAIL health_clr got=%b want=0", health_fail); end
`else
        total++;
        if (health_fail !== 1'b0) begin bad++; $display("[TB] FAIL health_off got=%b want=0", health_fail); end
        doReset();
`endif
        for (int i = 0; i < W; i++) feedPair(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000000 || health_fail !== 1'b0) begin
            bad++;
            $display("[TB] FAIL health_fresh valid=%b data=%h health=%b want 1/00000000/0", out_valid, out_data, health_fail);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 17; i++) feedPair(1'b0, 1'b1, 1'b1);
        total++;
        if (fill_level !== FW'(17)) begin bad++; $display("[TB] FAIL mid_fill got=%0d want=17", fill_level); end
        doReset();
        total++;
        if (fill_level !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset fill=%0d valid=%b want 0/0", fill_level, out_valid);
        end
        for (int i = 0; i < W; i++) feedPair(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF) begin
            bad++;
            $display("[TB] FAIL mid_word valid=%b data=%h want 1/ffffffff", out_valid, out_data);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 63) == 0));
            total++;
            if (out_valid !== mSlotValid || fill_level !== FW'(mBits.size()) || health_fail !== mFail ||
                (mSlotValid && out_data !== mSlotWord)) begin
                bad++;
                $display("[TB] FAIL rand_cyc%0d valid=%b fill=%0d health=%b data=%h want valid=%b fill=%0d health=%b data=%h",
                         i, out_valid, fill_level, health_fail, out_data,
                         mSlotValid, mBits.size(), mFail, mSlotWord);
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_packing();
        test_bias();
        test_back_to_back();
        test_health();
        test_reset_mid_word();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
